// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared types and helpers for the N-way traffic-light controller.
//   phase_t    : phase encoding, also driven on the controller's phase output
//   LAMP_*     : bit position of each lamp inside a way's 3-bit {R,Y,G} field
//   lamp_code  : {R,Y,G} pattern of one way for a given phase
// -----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN   = 2'd0,
        YELLOW  = 2'd1,
        ALL_RED = 2'd2,
        FLASH   = 2'd3
    } phase_t;

    localparam int LAMP_G = 0;
    localparam int LAMP_Y = 1;
    localparam int LAMP_R = 2;

    // Lamp pattern of one way. Outside FLASH exactly one lamp is lit.
    function automatic logic [2:0] lamp_code(input phase_t ph,
                                             input logic   is_active,
                                             input logic   flash_y);
        logic [2:0] code;
        code = 3'b000;
        case (ph)
            GREEN: begin
                if (is_active) code[LAMP_G] = 1'b1;
                else           code[LAMP_R] = 1'b1;
            end
            YELLOW: begin
                if (is_active) code[LAMP_Y] = 1'b1;
                else           code[LAMP_R] = 1'b1;
            end
            ALL_RED: code[LAMP_R] = 1'b1;
            FLASH:   code[LAMP_Y] = flash_y;
            default: code[LAMP_R] = 1'b1;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Divides clk down to a one-cycle tick every CLK_HZ/TICK_HZ clocks.
//   clk  in  : system clock
//   rst  in  : asynchronous reset, active-low (counter and tick cleared)
//   tick out : registered pulse, high for the cycle after the counter wraps
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 1
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt_r;

    // Free-running divider; tick is registered so it is glitch-free.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {PW{1'b0}};
            tick  <= 1'b0;
        end else if (cnt_r == LAST) begin
            cnt_r <= {PW{1'b0}};
            tick  <= 1'b1;
        end else begin
            cnt_r <= cnt_r + PW'(1);
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/traffic_ctrl_nway.sv
// -----------------------------------------------------------------------------
// traffic_ctrl_nway
// Round-robin N-way traffic-light controller with demand-based skipping.
// GREEN -> YELLOW -> ALL_RED per way; a GREEN with no competing demand is
// extended. Optional night mode (macro TRAFFIC_NIGHT_EN) adds the night
// input and a flashing-yellow FLASH phase.
//   clk        in  : system clock
//   rst        in  : asynchronous reset, active-low
//   req        in  : per-way demand (level)
//   night      in  : night-mode request (only with TRAFFIC_NIGHT_EN)
//   lights     out : way i = lights[3i+2:3i] = {R,Y,G}
//   active_way out : way owning green/yellow
//   phase      out : 0 GREEN, 1 YELLOW, 2 ALL_RED, 3 FLASH
//   count      out : ticks remaining in current phase
//   tick       out : prescaler pulse
// All outputs are registered.
// -----------------------------------------------------------------------------
module traffic_ctrl_nway
    import traffic_pkg::*;
#(
    parameter int N_WAYS   = 4,
    parameter int CLK_HZ   = 100000000,
    parameter int TICK_HZ  = 1,
    parameter int GREEN_T  = 9,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 1,
    parameter int CNT_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_WAYS-1:0]         req,
`ifdef TRAFFIC_NIGHT_EN
    input  logic                      night,
`endif
    output logic [3*N_WAYS-1:0]       lights,
    output logic [$clog2(N_WAYS)-1:0] active_way,
    output logic [1:0]                phase,
    output logic [CNT_W-1:0]          count,
    output logic                      tick
);

    localparam int W = $clog2(N_WAYS);
    localparam logic [CNT_W-1:0] GREEN_C  = CNT_W'(GREEN_T);
    localparam logic [CNT_W-1:0] YELLOW_C = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] ALLRED_C = CNT_W'(ALLRED_T);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [W:0]       NW_C     = (W+1)'(N_WAYS);

    phase_t               phase_r, phase_nxt_s;
    logic [W-1:0]         way_r, way_nxt_s;
    logic [W-1:0]         next_r, next_nxt_s;
    logic [CNT_W-1:0]     count_r, count_nxt_s;
    logic                 flash_y_r, flash_y_nxt_s;
    logic [3*N_WAYS-1:0]  lights_r, lights_nxt_s;
    logic                 found_s;
    logic [W-1:0]         found_way_s;
    logic [W:0]           sum_s;
    logic                 night_s;

    // Full lamp vector for a given phase / owning way / flash state.
    function automatic logic [3*N_WAYS-1:0] decode(input phase_t       ph,
                                                   input logic [W-1:0] w,
                                                   input logic         fy);
        logic [3*N_WAYS-1:0] v;
        v = {(3*N_WAYS){1'b0}};
        for (int i = 0; i < N_WAYS; i++) begin
            v[3*i +: 3] = lamp_code(ph, (W'(i) == w), fy);
        end
        return v;
    endfunction

`ifdef TRAFFIC_NIGHT_EN
    assign night_s = night;
`else
    assign night_s = 1'b0;
`endif

    tick_prescaler #(
        .CLK_HZ  (CLK_HZ),
        .TICK_HZ (TICK_HZ)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Round-robin search: first requesting way after the active one.
    // The active way itself is never considered.
    always_comb begin
        found_s     = 1'b0;
        found_way_s = way_r;
        sum_s       = {(W+1){1'b0}};
        for (int k = 1; k < N_WAYS; k++) begin
            sum_s = {1'b0, way_r} + (W+1)'(k);
            sum_s = (sum_s >= NW_C) ? (sum_s - NW_C) : sum_s;
            if (!found_s && req[sum_s[W-1:0]]) begin
                found_s     = 1'b1;
                found_way_s = sum_s[W-1:0];
            end else begin
                found_s     = found_s;
            end
        end
    end

    // Next-state logic; everything advances only on tick.
    always_comb begin
        phase_nxt_s   = phase_r;
        way_nxt_s     = way_r;
        next_nxt_s    = next_r;
        count_nxt_s   = count_r;
        flash_y_nxt_s = flash_y_r;
        if (tick) begin
            if (night_s) begin
                // Night wins from any phase; Y toggles while already flashing.
                phase_nxt_s   = FLASH;
                count_nxt_s   = {CNT_W{1'b0}};
                flash_y_nxt_s = (phase_r == FLASH) ? ~flash_y_r : 1'b1;
            end else if (phase_r == FLASH) begin
                // Leave night mode through a clearance; same way gets green.
                phase_nxt_s   = ALL_RED;
                count_nxt_s   = ALLRED_C;
                next_nxt_s    = way_r;
                flash_y_nxt_s = 1'b0;
            end else if (count_r > ONE_C) begin
                count_nxt_s   = count_r - ONE_C;
            end else begin
                case (phase_r)
                    GREEN: begin
                        if (found_s) begin
                            phase_nxt_s = YELLOW;
                            next_nxt_s  = found_way_s;
                            count_nxt_s = YELLOW_C;
                        end else begin
                            count_nxt_s = GREEN_C;
                        end
                    end
                    YELLOW: begin
                        phase_nxt_s = ALL_RED;
                        count_nxt_s = ALLRED_C;
                    end
                    ALL_RED: begin
                        phase_nxt_s = GREEN;
                        way_nxt_s   = next_r;
                        count_nxt_s = GREEN_C;
                    end
                    default: begin
                        phase_nxt_s = ALL_RED;
                        count_nxt_s = ALLRED_C;
                        next_nxt_s  = way_r;
                    end
                endcase
            end
        end else begin
            phase_nxt_s = phase_r;
        end
        lights_nxt_s = decode(phase_nxt_s, way_nxt_s, flash_y_nxt_s);
    end

    // State and registered output update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_r   <= GREEN;
            way_r     <= {W{1'b0}};
            next_r    <= {W{1'b0}};
            count_r   <= GREEN_C;
            flash_y_r <= 1'b0;
            lights_r  <= decode(GREEN, {W{1'b0}}, 1'b0);
        end else begin
            phase_r   <= phase_nxt_s;
            way_r     <= way_nxt_s;
            next_r    <= next_nxt_s;
            count_r   <= count_nxt_s;
            flash_y_r <= flash_y_nxt_s;
            lights_r  <= lights_nxt_s;
        end
    end

    assign lights     = lights_r;
    assign active_way = way_r;
    assign phase      = phase_r;
    assign count      = count_r;

endmodule

// File: tb/tb_traffic_ctrl_nway.sv
// -----------------------------------------------------------------------------
// tb_traffic_ctrl_nway
// Directed bench: expected per-tick states are queued before the ticks they
// describe and popped/compared once the controller has updated. A negedge
// monitor checks lamp exclusivity every cycle outside FLASH.
// Night-mode steps run only when TRAFFIC_NIGHT_EN is defined.
// -----------------------------------------------------------------------------
module tb_traffic_ctrl_nway;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = 4'b0000;
`ifdef TRAFFIC_NIGHT_EN
    logic        night = 1'b0;
`endif
    logic [11:0] lights;
    logic [1:0]  active_way;
    logic [1:0]  phase;
    logic [3:0]  count;
    logic        tick;

    traffic_ctrl_nway #(
        .N_WAYS   (4),
        .CLK_HZ   (10),
        .TICK_HZ  (1),
        .GREEN_T  (3),
        .YELLOW_T (2),
        .ALLRED_T (1),
        .CNT_W    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
`ifdef TRAFFIC_NIGHT_EN
        .night      (night),
`endif
        .lights     (lights),
        .active_way (active_way),
        .phase      (phase),
        .count      (count),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] ph;
        logic [1:0] way;
        logic [3:0] cnt;
        logic       fy;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   last_gap = 0;

    // {R,Y,G} per way as described for each phase.
    function automatic logic [11:0] model_lights(input logic [1:0] ph,
                                                 input logic [1:0] way,
                                                 input logic       fy);
        logic [11:0] l;
        l = 12'h000;
        for (int i = 0; i < 4; i++) begin
            if (ph == 2'd3)                        l[3*i +: 3] = {1'b0, fy, 1'b0};
            else if (ph == 2'd2 || i != int'(way)) l[3*i +: 3] = 3'b100;
            else if (ph == 2'd0)                   l[3*i +: 3] = 3'b001;
            else                                   l[3*i +: 3] = 3'b010;
        end
        return l;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [1:0] ph, input logic [1:0] way,
                        input logic [3:0] cnt, input logic fy);
        exp_t e;
        e.ph = ph; e.way = way; e.cnt = cnt; e.fy = fy;
        sb_q.push_back(e);
    endtask

    // One full service of way w ending with green handed to nxt.
    task automatic push_cycle(input logic [1:0] w, input logic [1:0] nxt);
        push(2'd0, w, 4'd2, 1'b0);
        push(2'd0, w, 4'd1, 1'b0);
        push(2'd1, w, 4'd2, 1'b0);
        push(2'd1, w, 4'd1, 1'b0);
        push(2'd2, w, 4'd1, 1'b0);
        push(2'd0, nxt, 4'd3, 1'b0);
    endtask

    // Bounded wait for tick, then for the edge that consumes it.
    task automatic wait_tick();
        int n;
        n = 0;
        while (tick !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        last_gap = n;
        chk("tick_seen", {31'd0, tick}, 32'd1);
        @(negedge clk);
    endtask

    task automatic run_ticks(input int n);
        exp_t e;
        for (int t = 0; t < n; t++) begin
            wait_tick();
            chk("sb_nonempty", {31'd0, (sb_q.size() == 0)}, 32'd0);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("phase", {30'd0, phase}, {30'd0, e.ph});
                chk("active_way", {30'd0, active_way}, {30'd0, e.way});
                chk("count", {28'd0, count}, {28'd0, e.cnt});
                chk("lights", {20'd0, lights}, {20'd0, model_lights(e.ph, e.way, e.fy)});
            end
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_phase"}, {30'd0, phase}, 32'd0);
        chk({tag, "_way"}, {30'd0, active_way}, 32'd0);
        chk({tag, "_count"}, {28'd0, count}, 32'd3);
        chk({tag, "_lights"}, {20'd0, lights}, {20'd0, 12'b100_100_100_001});
        chk({tag, "_tick"}, {31'd0, tick}, 32'd0);
    endtask

    // Every cycle outside FLASH: one lamp per way, at most one way G or Y.
    always @(negedge clk) begin
        int ng;
        logic [2:0] lamp;
        if (phase !== 2'd3) begin
            ng = 0;
            for (int i = 0; i < 4; i++) begin
                lamp = lights[3*i +: 3];
                chk("one_lamp_per_way", $countones(lamp), 32'd1);
                if (lamp[0] | lamp[1]) ng++;
            end
            chk("single_go_way", {31'd0, (ng > 1)}, 32'd0);
        end
    end

    initial begin
        // Reset state
        #1 rst = 1'b0;
        #2 chk_reset_state("reset");
        @(negedge clk);
        rst = 1'b1;

        // 1: all ways request -> full round robin, back to way0 after 24 ticks
        req = 4'b1111;
        for (int w = 0; w < 4; w++) push_cycle(2'(w), 2'((w + 1) % 4));
        run_ticks(1);
        chk("first_tick_gap", last_gap, 32'd10);
        run_ticks(1);
        chk("tick_period", last_gap, 32'd9);
        run_ticks(22);

        // 2: only ways 0 and 3 request -> 0,3,0
        req = 4'b1001;
        push_cycle(2'd0, 2'd3);
        push_cycle(2'd3, 2'd0);
        run_ticks(12);

        // 3: no demand -> way0 green extended, never yellow
        req = 4'b0000;
        for (int r = 0; r < 2; r++) begin
            push(2'd0, 2'd0, 4'd2, 1'b0);
            push(2'd0, 2'd0, 4'd1, 1'b0);
            push(2'd0, 2'd0, 4'd3, 1'b0);
        end
        run_ticks(6);

        // 4: way2 request dropped during yellow still receives green
        req = 4'b0100;
        push(2'd0, 2'd0, 4'd2, 1'b0);
        push(2'd0, 2'd0, 4'd1, 1'b0);
        push(2'd1, 2'd0, 4'd2, 1'b0);
        run_ticks(3);
        req = 4'b0000;
        push(2'd1, 2'd0, 4'd1, 1'b0);
        push(2'd2, 2'd0, 4'd1, 1'b0);
        push(2'd0, 2'd2, 4'd3, 1'b0);
        run_ticks(3);

        // 5: reset asserted mid-yellow -> immediate reset state, prescaler restarts
        req = 4'b1111;
        push(2'd0, 2'd2, 4'd2, 1'b0);
        push(2'd0, 2'd2, 4'd1, 1'b0);
        push(2'd1, 2'd2, 4'd2, 1'b0);
        run_ticks(3);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_reset_state("mid_reset");
        @(negedge clk);
        rst = 1'b1;
        push(2'd0, 2'd0, 4'd2, 1'b0);
        run_ticks(1);
        chk("restart_tick_gap", last_gap, 32'd10);

`ifdef TRAFFIC_NIGHT_EN
        // 6: night during GREEN way1 -> flashing yellow, then ALL_RED, GREEN way1
        push(2'd0, 2'd0, 4'd1, 1'b0);
        push(2'd1, 2'd0, 4'd2, 1'b0);
        push(2'd1, 2'd0, 4'd1, 1'b0);
        push(2'd2, 2'd0, 4'd1, 1'b0);
        push(2'd0, 2'd1, 4'd3, 1'b0);
        run_ticks(5);
        night = 1'b1;
        push(2'd3, 2'd1, 4'd0, 1'b1);
        push(2'd3, 2'd1, 4'd0, 1'b0);
        push(2'd3, 2'd1, 4'd0, 1'b1);
        run_ticks(3);
        night = 1'b0;
        push(2'd2, 2'd1, 4'd1, 1'b0);
        push(2'd0, 2'd1, 4'd3, 1'b0);
        run_ticks(2);
`endif

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
